iz_param_sequencer: RTL and testbench
=====================================

IZ_PARAM_SEQUENCER -- requirements
Module: iz_param_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the maximum number of WAIT_RDY cycles before an error is flagged (range 2..255).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request to program one parameter set; sampled only in IDLE.
REQ-005 SHALL have ports cfg_a, cfg_b, cfg_c, cfg_d  input  16 each  signed neuron parameters a/b/c/d (Q8.8), captured on an accepted start.
REQ-006 SHALL have port hold  input  1  stall request; freezes the serial stream without losing position.
REQ-007 SHALL have port params_ready  input  1  ready flag returned by the downstream serial parameter loader.
REQ-008 SHALL have port ser_data  output  1  serial bit to the loader's serial data input.
REQ-009 SHALL have port ser_load  output  1  load strobe to the loader's load-enable input.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port done  output  1  one-cycle pulse on successful completion.
REQ-012 SHALL have port err  output  1  sticky error flag; cleared by the next accepted start or by reset.

Function
REQ-013 SHALL implement the states IDLE, ARM, SHIFT, WAIT_RDY and DONE; all outputs SHALL be registered.
REQ-014 In IDLE with start=1 and hold=0, SHALL capture {cfg_a,cfg_b,cfg_c,cfg_d} into a 64-bit shift register, clear err, clear the bit counter and the drop flag, and go to ARM; start while busy=1 SHALL be ignored.
REQ-015 ARM SHALL drive ser_load=1 and ser_data=0 for exactly one cycle, forming the loader's rising-edge arm cycle, then go to SHIFT; with hold=1, ARM SHALL drive ser_load=0 and remain in ARM.
REQ-016 SHIFT SHALL drive ser_load=1 with ser_data equal to the shift-register MSB, ordered a[15]..a[0], b[15]..b[0], c[15]..c[0], d[15]..d[0], advancing one bit per cycle for 64 cycles.
REQ-017 In SHIFT with hold=1, SHALL drive ser_load=0, keep ser_data unchanged, and freeze the bit counter and shift register; on hold release, SHALL resume at the same bit with no re-arm.
REQ-018 During SHIFT, params_ready=0 sampled in any cycle SHALL set the drop flag, confirming that the loader accepted the arm.
REQ-019 After bit 63 is driven, SHALL go to WAIT_RDY with ser_load=0 and ser_data=0, and SHALL clear the timeout counter.
REQ-020 In WAIT_RDY, params_ready=1 with the drop flag set SHALL move to DONE.
REQ-021 In WAIT_RDY, params_ready=1 with the drop flag clear SHALL set err=1 and move to IDLE with no done pulse (stale-ready condition).
REQ-022 In WAIT_RDY, TIMEOUT_CYCLES cycles without params_ready=1 SHALL set err=1 and move to IDLE.
REQ-023 hold SHALL have no effect in WAIT_RDY or DONE.
REQ-024 DONE SHALL assert done=1 for one cycle and return to IDLE; busy SHALL be 0 in DONE's successor cycle.
REQ-025 Latency from the start-sampling edge to done=1 SHALL be 67 cycles when hold=0 throughout and the loader responds immediately.
REQ-026 The bit counter SHALL be 6 bits wide; the timeout counter SHALL be 8 bits wide and saturate at TIMEOUT_CYCLES.

Reset
REQ-027 Asserting rst_n=0 SHALL immediately force state IDLE and ser_data=0, ser_load=0, busy=0, done=0, err=0, and clear all counters, the drop flag and the shift register, including during SHIFT.
REQ-028 After a mid-stream reset, the system SHALL also reset the loader; the sequencer does not re-synchronise a partially loaded loader.

Verification
REQ-029 Scenario: cfg a=51, b=51, c=-16640, d=512, start pulse, hold=0 -> ser_load high for 65 cycles; bitstream 0x0033_0033_BF00_0200 MSB-first; done at cycle 67; loader outputs match the cfg values.
REQ-030 Scenario: hold=1 for 5 cycles after bit 20 -> ser_load=0 for those 5 cycles, no bit lost or duplicated, done at cycle 72.
REQ-031 Scenario: params_ready tied 0 -> err=1 after 16 WAIT_RDY cycles, no done pulse, busy=0.
REQ-032 Scenario: params_ready tied 1 -> err=1 at the first WAIT_RDY cycle (stale ready), no done pulse.
REQ-033 Scenario: start pulsed again during SHIFT -> ignored, stream unchanged; rst_n=0 at bit 30 -> all outputs 0 asynchronously.
REQ-034 Scenario: start and hold both high in IDLE -> no capture; start alone on the next cycle -> normal sequence.

Source files
------------

// File: rtl/iz_param_sequencer.sv
// Purpose : serialises one Izhikevich parameter set {a,b,c,d} (Q8.8, 64 bits MSB-first) into a serial loader, then waits for its ready.
// Latency : done is asserted 67 cycles after the start-sampling edge when hold stays low and the loader's ready returns immediately.
// Backpressure: hold freezes the stream with ser_load low; WAIT_RDY gives up after TIMEOUT_CYCLES and sets the sticky err.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start                      request to program one set (accepted only in IDLE with hold low)
//   cfg_a..cfg_d [15:0]        parameters captured on an accepted start
//   hold                       stall request for ARM/SHIFT
//   params_ready               ready flag from the downstream loader
//   ser_data, ser_load         serial data and load strobe to the loader
//   busy, done, err            status: not-idle, one-cycle success pulse, sticky error
module iz_param_sequencer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] cfg_a,
    input  logic [15:0] cfg_b,
    input  logic [15:0] cfg_c,
    input  logic [15:0] cfg_d,
    input  logic        hold,
    input  logic        params_ready,
    output logic        ser_data,
    output logic        ser_load,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ARM      = 3'd1,
        SHIFT    = 3'd2,
        WAIT_RDY = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam logic [7:0] TMO_MAX = 8'(TIMEOUT_CYCLES);

    state_t      state, state_n;
    logic [63:0] sr, sr_n;
    logic [5:0]  bit_cnt, bit_cnt_n;   // index of the bit currently on ser_data
    logic [7:0]  tmo_cnt, tmo_cnt_n;
    logic        drop, drop_n;         // loader pulled ready low, i.e. it took the arm
    logic        ser_data_n, ser_load_n, busy_n, done_n, err_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sr       <= 64'd0;
            bit_cnt  <= 6'd0;
            tmo_cnt  <= 8'd0;
            drop     <= 1'b0;
            ser_data <= 1'b0;
            ser_load <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_n;
            sr       <= sr_n;
            bit_cnt  <= bit_cnt_n;
            tmo_cnt  <= tmo_cnt_n;
            drop     <= drop_n;
            ser_data <= ser_data_n;
            ser_load <= ser_load_n;
            busy     <= busy_n;
            done     <= done_n;
            err      <= err_n;
        end
    end

    // Outputs are computed for the state being entered and registered with it,
    // so each state's outputs appear in the same cycle the state is held.
    always_comb begin
        state_n    = state;
        sr_n       = sr;
        bit_cnt_n  = bit_cnt;
        tmo_cnt_n  = tmo_cnt;
        drop_n     = drop;
        ser_data_n = 1'b0;
        ser_load_n = 1'b0;
        done_n     = 1'b0;
        err_n      = err;

        case (state)
            IDLE: begin
                if (start && !hold) begin
                    sr_n       = {cfg_a, cfg_b, cfg_c, cfg_d};
                    err_n      = 1'b0;
                    bit_cnt_n  = 6'd0;
                    drop_n     = 1'b0;
                    state_n    = ARM;
                    ser_load_n = 1'b1;     // arm cycle: load high, data low
                end
            end
            ARM: begin
                // The arm cycle has already been presented; a hold here only
                // delays the first data bit.
                if (!hold) begin
                    state_n    = SHIFT;
                    ser_data_n = sr[63];
                    ser_load_n = 1'b1;
                    sr_n       = {sr[62:0], 1'b0};
                    bit_cnt_n  = 6'd0;
                end
            end
            SHIFT: begin
                if (!params_ready) begin
                    drop_n = 1'b1;
                end
                if (hold) begin
                    // The bit on ser_data was already consumed; keep it
                    // visible with load low and resume at the next bit.
                    ser_data_n = ser_data;
                end else if (bit_cnt == 6'd63) begin
                    state_n   = WAIT_RDY;
                    tmo_cnt_n = 8'd0;
                end else begin
                    ser_data_n = sr[63];
                    ser_load_n = 1'b1;
                    sr_n       = {sr[62:0], 1'b0};
                    bit_cnt_n  = bit_cnt + 6'd1;
                end
            end
            WAIT_RDY: begin
                if (params_ready) begin
                    if (drop) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                    end else begin
                        // Ready never dropped: it is stale from an earlier load.
                        err_n   = 1'b1;
                        state_n = IDLE;
                    end
                end else if (tmo_cnt == TMO_MAX - 8'd1) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else if (tmo_cnt < TMO_MAX) begin
                    tmo_cnt_n = tmo_cnt + 8'd1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_iz_param_sequencer.sv
// Purpose : directed self-checking bench for iz_param_sequencer with a behavioural serial loader.
// Latency : cycle 1 is the ARM cycle after the start-sampling edge; done is expected in cycle 67 (+hold cycles).
// Backpressure: hold driven from a per-run schedule; params_ready from the loader or tied 0/1.
module tb_iz_param_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        hold = 1'b0;
    logic [15:0] cfg_a = 16'd0, cfg_b = 16'd0, cfg_c = 16'd0, cfg_d = 16'd0;
    logic        params_ready;
    logic        ser_data, ser_load, busy, done, err;

    int checks = 0;
    int errors = 0;
    int rdy_mode = 0;          // 0: loader model, 1: tied 0, 2: tied 1

    always #5 clk = ~clk;

    iz_param_sequencer #(.TIMEOUT_CYCLES(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .cfg_a        (cfg_a),
        .cfg_b        (cfg_b),
        .cfg_c        (cfg_c),
        .cfg_d        (cfg_d),
        .hold         (hold),
        .params_ready (params_ready),
        .ser_data     (ser_data),
        .ser_load     (ser_load),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    // Loader model: first load-high cycle arms it (ready drops), then 64
    // load-high cycles shift data in MSB-first; ready rises after the last bit.
    logic        ldr_loading, ldr_rdy;
    logic [5:0]  ldr_cnt;
    logic [63:0] ldr_sr, ldr_out;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ldr_loading <= 1'b0;
            ldr_rdy     <= 1'b1;
            ldr_cnt     <= 6'd0;
            ldr_sr      <= 64'd0;
            ldr_out     <= 64'd0;
        end else if (ser_load) begin
            if (!ldr_loading) begin
                ldr_loading <= 1'b1;
                ldr_rdy     <= 1'b0;
                ldr_cnt     <= 6'd0;
            end else begin
                ldr_sr  <= {ldr_sr[62:0], ser_data};
                ldr_cnt <= ldr_cnt + 6'd1;
                if (ldr_cnt == 6'd63) begin
                    ldr_loading <= 1'b0;
                    ldr_rdy     <= 1'b1;
                    ldr_out     <= {ldr_sr[62:0], ser_data};
                end
            end
        end
    end

    assign params_ready = (rdy_mode == 0) ? ldr_rdy : (rdy_mode == 2);

    // Results of the last run
    logic [63:0] r_stream;
    int          r_ld, r_gap, r_dn, r_done_cyc, r_err_cyc;
    logic        r_moved, r_fin, r_err_c1;

    // Start one sequence and observe it cycle by cycle until busy falls.
    task automatic run(input logic [15:0] a, b, c, d,
                       input int start_at, input int hold_at, input int hold_len);
        int   cyc;
        logic held;
        r_stream = 64'd0; r_ld = 0; r_gap = 0; r_dn = 0; r_done_cyc = 0;
        r_err_cyc = 0; r_moved = 1'b0; r_fin = 1'b0; r_err_c1 = 1'b1;
        held = 1'b0;
        @(negedge clk);
        cfg_a = a; cfg_b = b; cfg_c = c; cfg_d = d;
        start = 1'b1;
        hold  = 1'b0;
        @(negedge clk);
        cyc = 1;
        while (cyc <= 300 && !r_fin) begin
            if (cyc == 1) r_err_c1 = err;
            if (ser_load) begin
                r_ld++;
                if (r_ld > 1) r_stream = {r_stream[62:0], ser_data};
                held = ser_data;
            end else if (r_ld >= 1 && r_ld < 65) begin
                r_gap++;
                if (ser_data !== held) r_moved = 1'b1;
            end
            if (done) begin
                r_dn++;
                r_done_cyc = cyc;
            end
            if (err && r_err_cyc == 0) r_err_cyc = cyc;
            if (!busy) r_fin = 1'b1;
            start = (cyc == start_at);
            hold  = (cyc >= hold_at) && (cyc < hold_at + hold_len);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        hold  = 1'b0;
        checks++;
        if (!r_fin) begin
            errors++;
            $display("FAIL run_terminates: busy still high after %0d cycles, required low", cyc);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++; if (ser_data !== 1'b0) begin errors++; $display("FAIL reset_ser_data: got %b want 0", ser_data); end
        checks++; if (ser_load !== 1'b0) begin errors++; $display("FAIL reset_ser_load: got %b want 0", ser_load); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        rdy_mode = 0;
        run(16'd51, 16'd51, 16'hBF00, 16'd512, 0, 0, 0);
        checks++; if (r_stream !== 64'h0033_0033_BF00_0200) begin errors++; $display("FAIL basic_stream: got %h want 0033_0033_bf00_0200", r_stream); end
        checks++; if (r_ld !== 65) begin errors++; $display("FAIL basic_load_cycles: got %0d want 65", r_ld); end
        checks++; if (r_done_cyc !== 67) begin errors++; $display("FAIL basic_done_cycle: got %0d want 67", r_done_cyc); end
        checks++; if (r_dn !== 1) begin errors++; $display("FAIL basic_done_pulses: got %0d want 1", r_dn); end
        checks++; if (r_err_cyc !== 0) begin errors++; $display("FAIL basic_err: err seen at cycle %0d, want never", r_err_cyc); end
        checks++; if (ldr_out[63:48] !== 16'd51) begin errors++; $display("FAIL basic_ldr_a: got %h want 0033", ldr_out[63:48]); end
        checks++; if (ldr_out[47:32] !== 16'd51) begin errors++; $display("FAIL basic_ldr_b: got %h want 0033", ldr_out[47:32]); end
        checks++; if (ldr_out[31:16] !== 16'hBF00) begin errors++; $display("FAIL basic_ldr_c: got %h want bf00", ldr_out[31:16]); end
        checks++; if (ldr_out[15:0] !== 16'h0200) begin errors++; $display("FAIL basic_ldr_d: got %h want 0200", ldr_out[15:0]); end
    endtask

    task automatic test_hold();
        rdy_mode = 0;
        // bit 20 is driven in cycle 22; hold is sampled at the 5 edges ending cycles 22..26
        run(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 0, 22, 5);
        checks++; if (r_stream !== 64'h1234_5678_9ABC_DEF0) begin errors++; $display("FAIL hold_stream: got %h want 1234_5678_9abc_def0", r_stream); end
        checks++; if (r_gap !== 5) begin errors++; $display("FAIL hold_gap: got %0d load-low cycles want 5", r_gap); end
        checks++; if (r_moved !== 1'b0) begin errors++; $display("FAIL hold_data_frozen: got moved=%b want 0", r_moved); end
        checks++; if (r_done_cyc !== 72) begin errors++; $display("FAIL hold_done_cycle: got %0d want 72", r_done_cyc); end
        checks++; if (ldr_out !== 64'h1234_5678_9ABC_DEF0) begin errors++; $display("FAIL hold_ldr: got %h want 1234_5678_9abc_def0", ldr_out); end
    endtask

    task automatic test_start_in_shift();
        rdy_mode = 0;
        run(16'h8001, 16'h00FF, 16'hFF00, 16'h7FFE, 10, 0, 0);
        checks++; if (r_stream !== 64'h8001_00FF_FF00_7FFE) begin errors++; $display("FAIL restart_stream: got %h want 8001_00ff_ff00_7ffe", r_stream); end
        checks++; if (r_done_cyc !== 67) begin errors++; $display("FAIL restart_done_cycle: got %0d want 67", r_done_cyc); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL restart_idle_after: busy=%b want 0", busy); end
    endtask

    task automatic test_timeout();
        rdy_mode = 1;
        run(16'h0001, 16'h0002, 16'h0003, 16'h0004, 0, 0, 0);
        checks++; if (r_err_cyc !== 82) begin errors++; $display("FAIL timeout_err_cycle: got %0d want 82", r_err_cyc); end
        checks++; if (r_dn !== 0) begin errors++; $display("FAIL timeout_no_done: got %0d pulses want 0", r_dn); end
        checks++; if (busy !== 1'b0 || err !== 1'b1) begin errors++; $display("FAIL timeout_final: busy=%b err=%b want busy=0 err=1", busy, err); end
        rdy_mode = 0;
    endtask

    task automatic test_stale();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL stale_err_sticky: got %b want 1", err); end
        rdy_mode = 2;
        run(16'h00AA, 16'h0055, 16'hAA00, 16'h5500, 0, 0, 0);
        checks++; if (r_err_c1 !== 1'b0) begin errors++; $display("FAIL stale_err_cleared_on_start: got %b want 0", r_err_c1); end
        checks++; if (r_err_cyc !== 67) begin errors++; $display("FAIL stale_err_cycle: got %0d want 67", r_err_cyc); end
        checks++; if (r_dn !== 0) begin errors++; $display("FAIL stale_no_done: got %0d pulses want 0", r_dn); end
        rdy_mode = 0;
    endtask

    task automatic test_start_hold_idle();
        @(negedge clk);
        start = 1'b1;
        hold  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hold  = 1'b0;
        checks++; if (busy !== 1'b0 || ser_load !== 1'b0) begin errors++; $display("FAIL start_hold_no_capture: busy=%b ser_load=%b want 0 0", busy, ser_load); end
        run(16'hC3C3, 16'h3C3C, 16'h0F0F, 16'hF0F0, 0, 0, 0);
        checks++; if (r_stream !== 64'hC3C3_3C3C_0F0F_F0F0) begin errors++; $display("FAIL start_hold_stream: got %h want c3c3_3c3c_0f0f_f0f0", r_stream); end
        checks++; if (r_done_cyc !== 67) begin errors++; $display("FAIL start_hold_done_cycle: got %0d want 67", r_done_cyc); end
    endtask

    task automatic test_reset_mid();
        int cyc;
        rdy_mode = 0;
        @(negedge clk);
        cfg_a = 16'h0000; cfg_b = 16'hFFFF; cfg_c = 16'h0000; cfg_d = 16'h0000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (cyc < 32) begin
            @(negedge clk);
            cyc++;
        end
        // cycle 32 carries bit 30 = b[1] = 1
        checks++; if (ser_data !== 1'b1 || ser_load !== 1'b1) begin errors++; $display("FAIL midrst_before: data=%b load=%b want 1 1", ser_data, ser_load); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({ser_data, ser_load, busy, done, err} !== 5'b0) begin errors++; $display("FAIL midrst_async: data/load/busy/done/err=%b want 00000", {ser_data, ser_load, busy, done, err}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0 || ser_load !== 1'b0) begin errors++; $display("FAIL midrst_stays_idle: busy=%b load=%b want 0 0", busy, ser_load); end
        run(16'd51, 16'd51, 16'hBF00, 16'd512, 0, 0, 0);
        checks++; if (r_done_cyc !== 67 || ldr_out !== 64'h0033_0033_BF00_0200) begin errors++; $display("FAIL midrst_recover: done_cyc=%0d ldr=%h want 67 0033_0033_bf00_0200", r_done_cyc, ldr_out); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_start_in_shift();
        test_timeout();
        test_stale();
        test_start_hold_idle();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
